led_matrix_scanner: RTL and testbench

//  Parametrised row-scan driver for bi-colour (red/green) LED dot matrices.

---
 rtl/led_matrix_scanner.sv | 111 +++++++++++
 tb/tb_led_matrix_scanner.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/led_matrix_scanner.sv
// Row-scan driver for bi-colour LED dot matrices. It double-buffers the frame,
// blanks the start of each row slot, and PWMs each colour's column drive.
module led_matrix_scanner #(
  parameter int ROWS      = 8,
  parameter int COLS      = 8,
  parameter int SCAN_DIV  = 1024,
  parameter int BLANK_CYC = 16,
  parameter int PWM_BITS  = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic [ROWS*COLS-1:0] frame_r,
  input  logic [ROWS*COLS-1:0] frame_g,
  input  logic                 frame_load,
  input  logic [PWM_BITS-1:0]  bright_r,
  input  logic [PWM_BITS-1:0]  bright_g,
  output logic                 frame_pend,
  output logic                 frame_sync,
  output logic [ROWS-1:0]      row,
  output logic [COLS-1:0]      col_r,
  output logic [COLS-1:0]      col_g
);

  localparam int SW = $clog2(SCAN_DIV);
  localparam int RW = $clog2(ROWS);
  localparam int N  = ROWS * COLS;

  logic [SW-1:0]       slot_cnt;
  logic [RW-1:0]       row_idx;
  logic [N-1:0]        disp_r, disp_g, pend_r, pend_g;
  logic                slot_end, frame_end, swap, blank;
  logic [SW-1:0]       pwm_diff;
  logic [PWM_BITS-1:0] pwm_pos;
  logic [ROWS-1:0]     row_sel;
  logic [COLS-1:0]     row_data_r, row_data_g;

  always_comb begin
    slot_end  = (slot_cnt == SW'(SCAN_DIV - 1));
    frame_end = slot_end && (row_idx == RW'(ROWS - 1));
    // While disabled there is no scan to tear, so a pending frame swaps at once.
    swap      = frame_pend && (!enable || frame_end);
    blank     = !enable || (slot_cnt < SW'(BLANK_CYC));
    pwm_diff  = slot_cnt - SW'(BLANK_CYC);
    pwm_pos   = pwm_diff[PWM_BITS-1:0];
  end

  always_comb begin
    row_sel    = '1;
    row_data_r = '0;
    row_data_g = '0;
    for (int i = 0; i < ROWS; i++) begin
      if (row_idx == RW'(i)) begin
        row_sel[i] = 1'b0;
        row_data_r = disp_r[i*COLS +: COLS];
        row_data_g = disp_g[i*COLS +: COLS];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || !enable) begin
      slot_cnt <= '0;
      row_idx  <= '0;
    end else if (slot_end) begin
      slot_cnt <= '0;
      row_idx  <= frame_end ? '0 : row_idx + RW'(1);
    end else begin
      slot_cnt <= slot_cnt + SW'(1);
    end
  end

  // A load coinciding with a swap keeps frame_pend set: display takes the old
  // pending data while the new data lands in the pending buffer.
  always_ff @(posedge clk) begin
    if (rst) begin
      disp_r     <= '0;
      disp_g     <= '0;
      pend_r     <= '0;
      pend_g     <= '0;
      frame_pend <= 1'b0;
    end else begin
      if (swap) begin
        disp_r <= pend_r;
        disp_g <= pend_g;
      end
      if (frame_load) begin
        pend_r     <= frame_r;
        pend_g     <= frame_g;
        frame_pend <= 1'b1;
      end else if (swap) begin
        frame_pend <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      row        <= '1;
      col_r      <= '0;
      col_g      <= '0;
      frame_sync <= 1'b0;
    end else begin
      row        <= blank ? '1 : row_sel;
      col_r      <= (!blank && (pwm_pos < bright_r)) ? row_data_r : '0;
      col_g      <= (!blank && (pwm_pos < bright_g)) ? row_data_g : '0;
      frame_sync <= enable && (row_idx == '0) && (slot_cnt == '0);
    end
  end

endmodule

// File: tb/tb_led_matrix_scanner.sv
// Bench for led_matrix_scanner: a scan-position model checked every cycle,
// plus literal expectations at hand-picked cycles of a directed scenario.
module tb_led_matrix_scanner;

  localparam int ROWS      = 8;
  localparam int COLS      = 8;
  localparam int SCAN_DIV  = 32;
  localparam int BLANK_CYC = 2;
  localparam int PWM_BITS  = 4;
  localparam int N         = ROWS * COLS;
  localparam int FRAME_LEN = ROWS * SCAN_DIV;

  logic                clk = 1'b0;
  logic                rst;
  logic                enable;
  logic [N-1:0]        frame_r, frame_g;
  logic                frame_load;
  logic [PWM_BITS-1:0] bright_r, bright_g;
  logic                frame_pend, frame_sync;
  logic [ROWS-1:0]     row;
  logic [COLS-1:0]     col_r, col_g;

  led_matrix_scanner #(
    .ROWS(ROWS), .COLS(COLS), .SCAN_DIV(SCAN_DIV),
    .BLANK_CYC(BLANK_CYC), .PWM_BITS(PWM_BITS)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable),
    .frame_r(frame_r), .frame_g(frame_g), .frame_load(frame_load),
    .bright_r(bright_r), .bright_g(bright_g),
    .frame_pend(frame_pend), .frame_sync(frame_sync),
    .row(row), .col_r(col_r), .col_g(col_g)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // model: scan position as one integer within the frame, plus frame stores
  int              m_pos = 0;
  logic [N-1:0]    m_disp_r = '0, m_disp_g = '0, m_pend_r = '0, m_pend_g = '0;
  bit              m_pend_flag = 1'b0;
  logic [ROWS-1:0] e_row;
  logic [COLS-1:0] e_col_r, e_col_g;
  logic            e_sync, e_pend;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    int r, s, ph;
    bit blk, bnd;
    logic [ROWS-1:0] one;
    one = 1;
    if (rst) begin
      e_row = '1; e_col_r = '0; e_col_g = '0; e_sync = 1'b0; e_pend = 1'b0;
      m_pos = 0; m_pend_flag = 1'b0;
      m_disp_r = '0; m_disp_g = '0; m_pend_r = '0; m_pend_g = '0;
    end else begin
      r   = m_pos / SCAN_DIV;
      s   = m_pos % SCAN_DIV;
      blk = !enable || (s < BLANK_CYC);
      ph  = blk ? 0 : (s - BLANK_CYC) % (1 << PWM_BITS);
      e_row   = blk ? '1 : ~(one << r);
      e_col_r = (!blk && ph < int'(bright_r)) ? m_disp_r[r*COLS +: COLS] : '0;
      e_col_g = (!blk && ph < int'(bright_g)) ? m_disp_g[r*COLS +: COLS] : '0;
      e_sync  = enable && (m_pos == 0);
      bnd = !enable || (m_pos == FRAME_LEN - 1);
      if (bnd && m_pend_flag) begin
        m_disp_r = m_pend_r;
        m_disp_g = m_pend_g;
        m_pend_flag = 1'b0;
      end
      if (frame_load) begin
        m_pend_r = frame_r;
        m_pend_g = frame_g;
        m_pend_flag = 1'b1;
      end
      m_pos  = enable ? (m_pos + 1) % FRAME_LEN : 0;
      e_pend = m_pend_flag;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check("model_row", 64'(row), 64'(e_row));
    check("model_col_r", 64'(col_r), 64'(e_col_r));
    check("model_col_g", 64'(col_g), 64'(e_col_g));
    check("model_sync", 64'(frame_sync), 64'(e_sync));
    check("model_pend", 64'(frame_pend), 64'(e_pend));
  endtask

  task automatic load_frame(input logic [N-1:0] r, input logic [N-1:0] g);
    frame_r    = r;
    frame_g    = g;
    frame_load = 1'b1;
  endtask

  task automatic literal_checks(input int k);
    string p;
    p = $sformatf("lit_k%0d", k);
    case (k)
      0:    begin check({p, "_sync"}, 64'(frame_sync), 64'd1); check({p, "_row"}, 64'(row), 64'hFF); end
      1:    begin check({p, "_sync"}, 64'(frame_sync), 64'd0); check({p, "_row"}, 64'(row), 64'hFF); end
      2:    begin check({p, "_row"}, 64'(row), 64'hFE); check({p, "_col_r"}, 64'(col_r), 64'h80); end
      9:    check({p, "_col_r"}, 64'(col_r), 64'h80);
      10:   check({p, "_col_r"}, 64'(col_r), 64'h00);
      16:   begin check({p, "_col_g"}, 64'(col_g), 64'h3C); check({p, "_col_r"}, 64'(col_r), 64'h00); end
      17:   check({p, "_col_g"}, 64'(col_g), 64'h00);
      18:   check({p, "_col_r"}, 64'(col_r), 64'h80);
      33:   check({p, "_row"}, 64'(row), 64'hFF);
      34:   begin
              check({p, "_row"}, 64'(row), 64'hFD);
              check({p, "_col_r"}, 64'(col_r), 64'h40);
              check({p, "_col_g"}, 64'(col_g), 64'hA5);
            end
      255:  check({p, "_sync"}, 64'(frame_sync), 64'd0);
      256:  check({p, "_sync"}, 64'(frame_sync), 64'd1);
      258:  begin check({p, "_row"}, 64'(row), 64'hFE); check({p, "_col_r"}, 64'(col_r), 64'h00); end
      356:  check({p, "_pend"}, 64'(frame_pend), 64'd1);
      510:  begin
              check({p, "_pend"}, 64'(frame_pend), 64'd1);
              check({p, "_col_r"}, 64'(col_r), 64'h01);
              check({p, "_row"}, 64'(row), 64'h7F);
            end
      511:  check({p, "_pend"}, 64'(frame_pend), 64'd0);
      512:  check({p, "_sync"}, 64'(frame_sync), 64'd1);
      514:  begin check({p, "_col_r"}, 64'(col_r), 64'h88); check({p, "_col_g"}, 64'(col_g), 64'h11); end
      767:  check({p, "_pend"}, 64'(frame_pend), 64'd1);
      770:  begin
              check({p, "_col_r"}, 64'(col_r), 64'hC3);
              check({p, "_col_g"}, 64'(col_g), 64'h00);
              check({p, "_pend"}, 64'(frame_pend), 64'd1);
            end
      1023: check({p, "_pend"}, 64'(frame_pend), 64'd0);
      1026: begin check({p, "_col_r"}, 64'(col_r), 64'h5A); check({p, "_col_g"}, 64'(col_g), 64'hA5); end
      1100: check({p, "_pend"}, 64'(frame_pend), 64'd1);
      1194: begin
              check({p, "_row"}, 64'(row), 64'hFF);
              check({p, "_col_r"}, 64'(col_r), 64'h00);
              check({p, "_pend"}, 64'(frame_pend), 64'd0);
              check({p, "_sync"}, 64'(frame_sync), 64'd0);
            end
      1195: check({p, "_sync"}, 64'(frame_sync), 64'd1);
      1197: begin
              check({p, "_row"}, 64'(row), 64'hFE);
              check({p, "_col_r"}, 64'(col_r), 64'h00);
              check({p, "_col_g"}, 64'(col_g), 64'h00);
            end
      1303: check({p, "_pend"}, 64'(frame_pend), 64'd1);
      1304: check({p, "_pend"}, 64'(frame_pend), 64'd0);
      1305: begin check({p, "_row"}, 64'(row), 64'hFF); check({p, "_sync"}, 64'(frame_sync), 64'd0); end
      1310: check({p, "_sync"}, 64'(frame_sync), 64'd1);
      1312: begin
              check({p, "_row"}, 64'(row), 64'hFE);
              check({p, "_col_r"}, 64'(col_r), 64'h0F);
              check({p, "_col_g"}, 64'(col_g), 64'hF0);
            end
      default: ;
    endcase
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; frame_load = 1'b0;
    frame_r = '0; frame_g = '0; bright_r = 4'd8; bright_g = 4'd15;

    for (int i = 0; i < 3; i++) tick();
    check("reset_row", 64'(row), 64'hFF);
    check("reset_col_r", 64'(col_r), 64'h00);
    check("reset_col_g", 64'(col_g), 64'h00);
    check("reset_pend", 64'(frame_pend), 64'd0);
    check("reset_sync", 64'(frame_sync), 64'd0);

    // frame A loaded while disabled swaps in on the next cycle
    rst = 1'b0;
    load_frame(64'h0102040810204080, 64'hA5A5A5A5A5A5A53C);
    tick();
    check("load_a_pend", 64'(frame_pend), 64'd1);
    frame_load = 1'b0;
    tick();
    check("swap_a_pend", 64'(frame_pend), 64'd0);

    for (int k = 0; k < 1330; k++) begin
      rst        = (k == 1194);
      enable     = !(k >= 1300 && k < 1310);
      frame_load = 1'b0;
      bright_r   = (k < 256) ? 4'd8 : ((k < 300) ? 4'd0 : 4'd15);
      case (k)
        356:  load_frame(64'h1122334455667788, 64'h8877665544332211);
        600:  load_frame(64'h00000000000000C3, 64'h0000000000000000);
        767:  load_frame(64'h000000000000005A, 64'h00000000000000A5);
        1100: load_frame(64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF);
        1303: load_frame(64'h000000000000000F, 64'h00000000000000F0);
        default: ;
      endcase
      tick();
      literal_checks(k);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
